// File: rtl/fetch_stage_pkg.sv
// Shared pipeline-buffer types for the fetch stage: IF/ID record, bubble
// instruction and fetch FSM states.
package PipelineBufferRegisters;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [8:0]  CurrPC;
    logic [31:0] CurrInstr;
  } IFID;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_e;

  function automatic logic [8:0] align_pc(input logic [8:0] addr);
    return {addr[8:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if;

  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, stall hold
// buffer and the IF/ID register.
module fetch_stage
  import PipelineBufferRegisters::*;
#(
  parameter logic [8:0]  RESET_PC  = 9'h000,
  parameter logic [31:0] NOP_INSTR = PipelineBufferRegisters::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [8:0]           branch_target,
  fetch_stage_if.master        imem,
  output IFID                  ifid_out,
  output logic                 ifid_valid,
  output logic [8:0]           pc_out
);

  fetch_state_e state_q, state_d;
  logic [8:0]   pc_q, pc_d;
  logic [8:0]   tgt_q, tgt_d;
  logic         drop_q, drop_d;
  logic [31:0]  hold_q, hold_d;
  IFID          ifid_q, ifid_d;
  logic         valid_q, valid_d;

  logic         bubble;
  logic         deliver;
  logic [31:0]  deliver_instr;
  logic [8:0]   flush_pc;

  assign flush_pc = align_pc(branch_target);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    drop_d        = drop_q;
    hold_d        = hold_q;
    ifid_d        = ifid_q;
    valid_d       = valid_q;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;
    // Any unstalled cycle that does not deliver an instruction inserts a bubble.
    bubble        = !stall || flush;

    unique case (state_q)
      StReq: begin
        if (flush) begin
          pc_d = flush_pc;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (imem.imem_ack) begin
          state_d = StReq;
          drop_d  = 1'b0;
          if (flush) begin
            pc_d = flush_pc;
          end else if (drop_q) begin
            // Response belongs to a squashed fetch; redirect to the latched target.
            pc_d = tgt_q;
          end else if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = StHold;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem.imem_rdata;
          end
        end else if (flush) begin
          tgt_d  = flush_pc;
          drop_d = 1'b1;
        end
      end

      StHold: begin
        if (flush) begin
          pc_d    = flush_pc;
          hold_d  = '0;
          state_d = StReq;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          hold_d        = '0;
          state_d       = StReq;
        end
      end

      default: state_d = StReq;
    endcase

    if (deliver) begin
      ifid_d  = '{CurrPC: pc_q, CurrInstr: deliver_instr};
      valid_d = 1'b1;
      pc_d    = pc_q + 9'd4;
    end else if (bubble) begin
      ifid_d  = '{CurrPC: pc_q, CurrInstr: NOP_INSTR};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      drop_q  <= 1'b0;
      hold_q  <= '0;
      ifid_q  <= '{CurrPC: RESET_PC, CurrInstr: NOP_INSTR};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

  // A flush in StReq redirects immediately, so no request may leave that cycle.
  assign imem.imem_req  = (state_q == StReq) && !flush && !reset;
  assign imem.imem_addr = pc_q;
  assign ifid_out       = ifid_q;
  assign ifid_valid     = valid_q;
  assign pc_out         = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/flush/ack traffic against a behavioural fetch model.
module tb_fetch_stage;
  import PipelineBufferRegisters::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [8:0]  branch_target;
  IFID         ifid_out;
  logic        ifid_valid;
  logic [8:0]  pc_out;

  fetch_stage_if imem_bus ();

  fetch_stage #(
    .RESET_PC (9'h000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .branch_target(branch_target),
    .imem         (imem_bus),
    .ifid_out     (ifid_out),
    .ifid_valid   (ifid_valid),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [8:0]  m_pc;
  logic [40:0] m_ifid;
  logic        m_valid;
  bit          m_outstanding;
  bit          m_buffered;
  logic [31:0] m_buf;
  bit          m_drop;
  logic [8:0]  m_tgt;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input bit st, input bit fl, input logic [8:0] tg, input bit ack,
                        input logic [31:0] rd);
    stall                  = st;
    flush                  = fl;
    branch_target          = tg;
    imem_bus.imem_ack      = ack;
    imem_bus.imem_rdata    = rd;
  endtask

  task automatic m_bubble();
    m_ifid  = {m_pc, NOP};
    m_valid = 1'b0;
  endtask

  task automatic m_deliver(input logic [31:0] instr);
    m_ifid  = {m_pc, instr};
    m_valid = 1'b1;
    m_pc    = m_pc + 9'd4;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 9'h0, 0, 32'h0);
    cyc();
    cyc();
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++;
      $display("FAIL reset_req got=%b exp=0", imem_bus.imem_req); end
    n_tests++; if (pc_out !== 9'h000) begin n_fail++;
      $display("FAIL reset_pc got=%h exp=000", pc_out); end
    n_tests++; if (ifid_out !== {9'h000, NOP}) begin n_fail++;
      $display("FAIL reset_ifid got=%h exp=%h", ifid_out, {9'h000, NOP}); end
    n_tests++; if (ifid_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    reset = 1'b0;
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 9'h000) begin n_fail++;
      $display("FAIL first_req got=%b/%h exp=1/000", imem_bus.imem_req, imem_bus.imem_addr); end
  endtask

  task automatic test_basic();
    cyc();
    set_in(0, 0, 9'h0, 1, 32'h0050_0093);
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++;
      $display("FAIL basic_wait_req got=%b exp=0", imem_bus.imem_req); end
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_out !== {9'h000, 32'h0050_0093} || ifid_valid !== 1'b1) begin n_fail++;
      $display("FAIL basic_first got=%h/%b exp=%h/1", ifid_out, ifid_valid,
               {9'h000, 32'h0050_0093}); end
    n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 9'h004) begin n_fail++;
      $display("FAIL basic_req2 got=%b/%h exp=1/004", imem_bus.imem_req, imem_bus.imem_addr); end
    cyc();
    set_in(0, 0, 9'h0, 1, 32'h00A0_0113);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_out !== {9'h004, 32'h00A0_0113} || ifid_valid !== 1'b1) begin n_fail++;
      $display("FAIL basic_second got=%h/%b exp=%h/1", ifid_out, ifid_valid,
               {9'h004, 32'h00A0_0113}); end
    n_tests++; if (pc_out !== 9'h008) begin n_fail++;
      $display("FAIL basic_pc got=%h exp=008", pc_out); end
  endtask

  task automatic test_stall_hold();
    cyc();
    set_in(1, 0, 9'h0, 1, 32'h0020_8233);
    cyc();
    set_in(1, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_out !== {9'h008, NOP} || ifid_valid !== 1'b0 || pc_out !== 9'h008)
    begin n_fail++;
      $display("FAIL stall_hold1 got=%h/%b/%h exp=%h/0/008", ifid_out, ifid_valid, pc_out,
               {9'h008, NOP}); end
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++;
      $display("FAIL stall_hold_req got=%b exp=0", imem_bus.imem_req); end
    cyc();
    #1;
    n_tests++; if (ifid_out !== {9'h008, NOP} || pc_out !== 9'h008) begin n_fail++;
      $display("FAIL stall_hold2 got=%h/%h exp=%h/008", ifid_out, pc_out, {9'h008, NOP}); end
    set_in(0, 0, 9'h0, 0, 32'h0);
    cyc();
    #1;
    n_tests++; if (ifid_out !== {9'h008, 32'h0020_8233} || ifid_valid !== 1'b1) begin n_fail++;
      $display("FAIL stall_release got=%h/%b exp=%h/1", ifid_out, ifid_valid,
               {9'h008, 32'h0020_8233}); end
    n_tests++; if (pc_out !== 9'h00C || imem_bus.imem_addr !== 9'h00C) begin n_fail++;
      $display("FAIL stall_release_pc got=%h exp=00c", pc_out); end
  endtask

  task automatic test_flush_wait();
    cyc();
    set_in(0, 1, 9'h043, 0, 32'h0);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    cyc();
    cyc();
    set_in(0, 0, 9'h0, 1, 32'hDEAD_BEEF);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_valid !== 1'b0 || ifid_out.CurrInstr !== NOP) begin n_fail++;
      $display("FAIL flush_wait_drop got=%h/%b exp=%h/0", ifid_out.CurrInstr, ifid_valid, NOP); end
    n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 9'h040) begin n_fail++;
      $display("FAIL flush_wait_addr got=%b/%h exp=1/040", imem_bus.imem_req,
               imem_bus.imem_addr); end
  endtask

  task automatic test_stall_flush();
    cyc();
    set_in(1, 0, 9'h0, 1, 32'h1234_5678);
    cyc();
    set_in(1, 1, 9'h100, 0, 32'h0);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_valid !== 1'b0 || ifid_out !== {9'h040, NOP}) begin n_fail++;
      $display("FAIL stall_flush_ifid got=%h/%b exp=%h/0", ifid_out, ifid_valid,
               {9'h040, NOP}); end
    n_tests++; if (pc_out !== 9'h100 || imem_bus.imem_addr !== 9'h100) begin n_fail++;
      $display("FAIL stall_flush_pc got=%h exp=100", pc_out); end
    cyc();
    set_in(0, 0, 9'h0, 1, 32'hCAFE_0013);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_out !== {9'h100, 32'hCAFE_0013} || ifid_valid !== 1'b1) begin n_fail++;
      $display("FAIL stall_flush_next got=%h/%b exp=%h/1", ifid_out, ifid_valid,
               {9'h100, 32'hCAFE_0013}); end
  endtask

  task automatic test_wrap();
    set_in(0, 1, 9'h1FF, 0, 32'h0);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (pc_out !== 9'h1FC || imem_bus.imem_addr !== 9'h1FC) begin n_fail++;
      $display("FAIL wrap_align got=%h exp=1fc", pc_out); end
    cyc();
    set_in(0, 0, 9'h0, 1, 32'h00B0_0193);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_out !== {9'h1FC, 32'h00B0_0193} || ifid_valid !== 1'b1) begin n_fail++;
      $display("FAIL wrap_ifid got=%h/%b exp=%h/1", ifid_out, ifid_valid,
               {9'h1FC, 32'h00B0_0193}); end
    n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 9'h000) begin n_fail++;
      $display("FAIL wrap_addr got=%b/%h exp=1/000", imem_bus.imem_req, imem_bus.imem_addr); end
  endtask

  task automatic test_reset_wait();
    set_in(0, 1, 9'h0A0, 0, 32'h0);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    cyc();
    reset = 1'b1;
    #1;
    n_tests++; if (pc_out !== 9'h000 || imem_bus.imem_req !== 1'b0 || ifid_valid !== 1'b0)
    begin n_fail++;
      $display("FAIL rst_wait_state got=%h/%b/%b exp=000/0/0", pc_out, imem_bus.imem_req,
               ifid_valid); end
    cyc();
    reset = 1'b0;
    set_in(0, 0, 9'h0, 1, 32'hBAD0_0013);
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 9'h000) begin n_fail++;
      $display("FAIL rst_wait_req got=%b/%h exp=1/000", imem_bus.imem_req, imem_bus.imem_addr); end
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_valid !== 1'b0 || ifid_out !== {9'h000, NOP}) begin n_fail++;
      $display("FAIL rst_wait_stale got=%h/%b exp=%h/0", ifid_out, ifid_valid,
               {9'h000, NOP}); end
    set_in(0, 0, 9'h0, 1, 32'h00C0_0213);
    cyc();
    set_in(0, 0, 9'h0, 0, 32'h0);
    #1;
    n_tests++; if (ifid_out !== {9'h000, 32'h00C0_0213} || ifid_valid !== 1'b1) begin n_fail++;
      $display("FAIL rst_wait_fresh got=%h/%b exp=%h/1", ifid_out, ifid_valid,
               {9'h000, 32'h00C0_0213}); end
  endtask

  task automatic test_random();
    bit          st, fl, ack, exp_req, mem_pending;
    int unsigned mem_delay;
    logic [8:0]  tg, tgt_al;
    logic [31:0] rd;

    reset = 1'b1;
    set_in(0, 0, 9'h0, 0, 32'h0);
    cyc();
    reset = 1'b0;
    m_pc = 9'h000; m_ifid = {9'h000, NOP}; m_valid = 1'b0;
    m_outstanding = 0; m_buffered = 0; m_buf = '0; m_drop = 0; m_tgt = '0;
    mem_pending = 0; mem_delay = 0;

    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      tg  = 9'($urandom);
      rd  = $urandom;
      ack = mem_pending && (mem_delay == 0);
      set_in(st, fl, tg, ack, rd);
      #1;
      exp_req = !m_outstanding && !m_buffered && !fl;
      n_tests++; if (imem_bus.imem_req !== exp_req) begin n_fail++;
        $display("FAIL rand_req cyc=%0d got=%b exp=%b", c, imem_bus.imem_req, exp_req); end
      n_tests++; if (pc_out !== m_pc || imem_bus.imem_addr !== m_pc) begin n_fail++;
        $display("FAIL rand_pc cyc=%0d got=%h/%h exp=%h", c, pc_out, imem_bus.imem_addr, m_pc); end
      n_tests++; if (ifid_out !== m_ifid || ifid_valid !== m_valid) begin n_fail++;
        $display("FAIL rand_ifid cyc=%0d got=%h/%b exp=%h/%b", c, ifid_out, ifid_valid,
                 m_ifid, m_valid); end

      tgt_al = {tg[8:2], 2'b00};
      if (m_outstanding) begin
        if (ack) begin
          m_outstanding = 0;
          if (fl) begin
            m_bubble(); m_pc = tgt_al; m_drop = 0;
          end else if (m_drop) begin
            if (!st) m_bubble();
            m_pc = m_tgt; m_drop = 0;
          end else if (st) begin
            m_buffered = 1; m_buf = rd;
          end else begin
            m_deliver(rd);
          end
        end else if (fl) begin
          m_bubble(); m_drop = 1; m_tgt = tgt_al;
        end else if (!st) begin
          m_bubble();
        end
      end else if (m_buffered) begin
        if (fl) begin
          m_bubble(); m_pc = tgt_al; m_buffered = 0;
        end else if (!st) begin
          m_buffered = 0; m_deliver(m_buf);
        end
      end else begin
        if (fl) begin
          m_bubble(); m_pc = tgt_al;
        end else begin
          m_outstanding = 1;
          if (!st) m_bubble();
        end
      end

      if (ack) mem_pending = 0;
      else if (mem_pending) mem_delay--;
      if (exp_req) begin
        mem_pending = 1;
        mem_delay   = $urandom_range(0, 2);
      end
      cyc();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    set_in(0, 0, 9'h0, 0, 32'h0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall_hold();
    test_flush_wait();
    test_stall_flush();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 9'h000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 stall  in  1  hazard unit: hold PC and IF/ID contents.
REQ-006 flush  in  1  branch taken in EX: discard fetched/in-flight work.
REQ-007 branch_target  in  9  redirect PC; bits [1:0] forced to 00.
REQ-008 imem_req  out  1  one-cycle instruction-memory request pulse.
REQ-009 imem_addr  out  9  request address, equal to current PC.
REQ-010 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-011 imem_ack  in  1  response strobe, earliest 1 cycle after imem_req.
REQ-012 ifid_out  out  IFID struct (41)  {CurrPC, CurrInstr} for IF/ID buffer.
REQ-013 ifid_valid  out  1  ifid_out holds a real instruction.
REQ-014 pc_out  out  9  current fetch PC.

Function
REQ-015 FSM states REQ, WAIT, HOLD; at most one outstanding memory request.
REQ-016 REQ: imem_req=1, imem_addr=pc for exactly one cycle -> WAIT.
REQ-017 WAIT, ack, no flush, no stall: ifid_out<={pc,imem_rdata}, ifid_valid<=1, pc<=pc+4 -> REQ.
REQ-018 WAIT, ack, stall: imem_rdata captured in hold buffer; ifid_out unchanged -> HOLD.
REQ-019 HOLD, stall deasserted: buffer loaded to ifid_out, ifid_valid<=1, pc<=pc+4 -> REQ.
REQ-020 Stall holds ifid_out, ifid_valid and pc unchanged in every state.
REQ-021 Any non-stall cycle without a new instruction: ifid_out<={pc,NOP_INSTR}, ifid_valid<=0.
REQ-022 Flush has priority over stall and ack: ifid_out<={pc,NOP_INSTR}, ifid_valid<=0, hold buffer discarded.
REQ-023 Flush in REQ or HOLD: pc<={branch_target[8:2],2'b00} -> REQ next cycle.
REQ-024 Flush in WAIT before ack: latch target, set drop_pending; stay WAIT; on ack discard rdata, pc<=target -> REQ.
REQ-025 Flush in same cycle as ack: rdata discarded, pc<=target -> REQ.
REQ-026 Second flush while drop_pending: latched target overwritten by newest.
REQ-027 PC increment modulo 512: 9'h1FC+4 -> 9'h000.
REQ-028 pc_out reflects pc register; imem_addr equals pc whenever imem_req=1.

Reset
REQ-029 reset asserted: pc=RESET_PC, state=REQ, drop_pending=0, hold buffer=0, imem_req=0.
REQ-030 reset asserted: ifid_out={RESET_PC,NOP_INSTR}, ifid_valid=0.
REQ-031 Reset mid-WAIT: outstanding request abandoned; an ack in the first cycle after release is ignored.
REQ-032 First imem_req issued in first clock edge after reset deassertion.

Structure
REQ-033 IFID typedef, NOP_INSTR constant and fetch FSM state enum live in shared package PipelineBufferRegisters.
REQ-034 Single module, no sub-modules; PC, FSM, hold buffer and IF/ID register in one block.

Verification
REQ-035 Reset release, ack 1 cycle after each req, rdata=0x00500093/0x00A00113 -> ifid_out {0x000,0x00500093} then {0x004,0x00A00113}, valid=1.
REQ-036 Ack arrives during stall with rdata 0x00208233 -> ifid_out unchanged, state HOLD; stall drops -> ifid_out {pc,0x00208233}, pc+4.
REQ-037 Flush with branch_target 9'h043 while WAIT, ack 3 cycles later -> rdata discarded, valid=0, next imem_addr 9'h040.
REQ-038 Stall and flush same cycle, target 9'h100 -> ifid_valid=0, ifid_out.CurrInstr=0x00000013, pc=9'h100.
REQ-039 PC at 9'h1FC, ack without stall -> ifid_out.CurrPC=9'h1FC, next imem_addr 9'h000.
REQ-040 Reset asserted in WAIT, ack one cycle after release -> ignored; pc=RESET_PC, fresh request issued.
